// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector of an N_IN-input
// function, samples F after a settle delay and scores the result against a golden table.
module truth_table_sweeper #(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<N_IN)-1:0]    expected,
  output logic [N_IN-1:0]         vec,
  input  logic                    f_in,
  output logic                    busy,
  output logic                    done,
  output logic [(1<<N_IN)-1:0]    table_out,
  output logic                    pass,
  output logic [N_IN:0]           mismatch_cnt,
  output logic [N_IN-1:0]         first_fail,
  output logic                    fail_valid
);

  localparam int TBL    = 1 << N_IN;
  localparam int WAIT_W = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     idx_q, idx_d;
  logic [WAIT_W-1:0]   settle_q, settle_d;
  logic [TBL-1:0]      exp_q, exp_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [TBL-1:0]      table_q, table_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       mcnt_q, mcnt_d;
  logic [N_IN-1:0]     ff_q, ff_d;
  logic                fv_q, fv_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    exp_d    = exp_q;
    vec_d    = vec_q;
    done_d   = 1'b0;
    table_d  = table_q;
    pass_d   = pass_q;
    mcnt_d   = mcnt_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    unique case (state_q)
      S_IDLE: begin
        vec_d = '0;
        if (start) begin
          exp_d    = expected;
          table_d  = '0;
          pass_d   = 1'b0;
          mcnt_d   = '0;
          ff_d     = '0;
          fv_d     = 1'b0;
          idx_d    = '0;
          settle_d = WAIT_W'(SETTLE_CYC);
          state_d  = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_SETTLE: begin
        // Counter is loaded with SETTLE_CYC, so leaving at 1 gives exactly SETTLE_CYC cycles here.
        settle_d = settle_q - WAIT_W'(1);
        if (settle_q == WAIT_W'(1)) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        table_d[idx_q] = f_in;
        if (f_in != exp_q[idx_q]) begin
          mcnt_d = mcnt_q + (N_IN+1)'(1);
          if (!fv_q) ff_d = idx_q;
          fv_d = 1'b1;
        end
        if (idx_q == N_IN'(TBL - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          pass_d  = (table_d == exp_q);
        end else begin
          idx_d    = idx_q + N_IN'(1);
          vec_d    = idx_q + N_IN'(1);
          settle_d = WAIT_W'(SETTLE_CYC);
          state_d  = (SETTLE_CYC == 0) ? S_SAMPLE : S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        vec_d   = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      settle_q <= '0;
      exp_q    <= '0;
      vec_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      table_q  <= '0;
      pass_q   <= 1'b0;
      mcnt_q   <= '0;
      ff_q     <= '0;
      fv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      exp_q    <= exp_d;
      vec_q    <= vec_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      table_q  <= table_d;
      pass_q   <= pass_d;
      mcnt_q   <= mcnt_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
    end
  end

  assign vec          = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign table_out    = table_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mcnt_q;
  assign first_fail   = ff_q;
  assign fail_valid   = fv_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE_CYC=1 and 0) driven by a
// table-lookup function, results scored against a popcount/lowest-bit model.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [2];
  logic [15:0] exp_in   [2];
  logic [3:0]  vec      [2];
  logic        f_in     [2];
  logic        busy     [2];
  logic        done     [2];
  logic [15:0] table_out[2];
  logic        pass     [2];
  logic [4:0]  mcnt     [2];
  logic [3:0]  ffail    [2];
  logic        fvalid   [2];
  logic [15:0] fn_tbl   [2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 2; i++) f_in[i] = fn_tbl[i][vec[i]];
  end

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(1)) dut_s1 (
    .clk(clk), .rst(rst), .start(start[0]), .expected(exp_in[0]), .vec(vec[0]),
    .f_in(f_in[0]), .busy(busy[0]), .done(done[0]), .table_out(table_out[0]),
    .pass(pass[0]), .mismatch_cnt(mcnt[0]), .first_fail(ffail[0]), .fail_valid(fvalid[0])
  );

  truth_table_sweeper #(.N_IN(4), .SETTLE_CYC(0)) dut_s0 (
    .clk(clk), .rst(rst), .start(start[1]), .expected(exp_in[1]), .vec(vec[1]),
    .f_in(f_in[1]), .busy(busy[1]), .done(done[1]), .table_out(table_out[1]),
    .pass(pass[1]), .mismatch_cnt(mcnt[1]), .first_fail(ffail[1]), .fail_valid(fvalid[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int popcount16(input logic [15:0] x);
    int n = 0;
    for (int k = 0; k < 16; k++) n += int'(x[k]);
    return n;
  endfunction

  function automatic int lowest_set(input logic [15:0] x);
    for (int k = 0; k < 16; k++) if (x[k]) return k;
    return 0;
  endfunction

  // One full sweep on instance s; optional spurious starts mid-sweep and on the done cycle.
  task automatic sweep(input int s, input logic [15:0] fn, input logic [15:0] ex,
                       input bit inject, input bit start_on_done);
    int per = (s == 0) ? 2 : 1;
    int lat = 16 * per + 1;
    int cyc;
    bit got;
    logic [15:0] diff;
    fn_tbl[s] = fn;
    exp_in[s] = ex;
    start[s]  = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    cyc = 1;
    got = 0;
    check("busy_after_start", busy[s], 1);
    while (!got && cyc < 200) begin
      if (done[s]) begin
        got = 1;
      end else begin
        if (cyc < lat) check("vec_step", vec[s], 32'((cyc - 1) / per));
        if (inject && (cyc == 3 || cyc == 20)) begin
          start[s]  = 1'b1;
          exp_in[s] = ~ex;
        end else begin
          start[s]  = 1'b0;
          exp_in[s] = ex;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    start[s]  = 1'b0;
    exp_in[s] = ex;
    check("done_cycle", cyc, lat);
    diff = fn ^ ex;
    check("table_out", table_out[s], fn);
    check("pass", pass[s], (fn == ex) ? 1 : 0);
    check("mismatch_cnt", mcnt[s], popcount16(diff));
    check("first_fail", ffail[s], lowest_set(diff));
    check("fail_valid", fvalid[s], (diff != 0) ? 1 : 0);
    check("busy_on_done", busy[s], 1);
    if (start_on_done) start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
    check("done_one_pulse", done[s], 0);
    check("busy_idle", busy[s], 0);
    check("vec_idle", vec[s], 0);
    @(posedge clk); #1;
    check("busy_stays_idle", busy[s], 0);
    check("results_hold", table_out[s], fn);
  endtask

  initial begin
    int cnt;
    bit saw_done;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; exp_in[i] = '0; fn_tbl[i] = 16'h6996;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_vec", vec[0], 0);
    check("rst_busy", busy[0], 0);
    check("rst_done", done[0], 0);
    check("rst_table", table_out[0], 0);
    check("rst_pass", pass[0], 0);
    check("rst_mcnt", mcnt[0], 0);
    check("rst_ffail", ffail[0], 0);
    check("rst_fvalid", fvalid[0], 0);

    sweep(0, 16'h6996, 16'h6996, 0, 0);
    sweep(0, 16'h6996, 16'h6997, 0, 0);
    sweep(0, 16'h6996, 16'h9669, 0, 0);
    sweep(0, 16'h6996, 16'h69D6, 0, 0);

    // reset mid-sweep
    fn_tbl[0] = 16'h6996; exp_in[0] = 16'h6996; start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    cnt = 0;
    while (vec[0] != 4'd5 && cnt < 100) begin
      @(posedge clk); #1 cnt++;
    end
    check("reached_vec5", (cnt < 100) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort_busy", busy[0], 0);
    check("abort_vec", vec[0], 0);
    check("abort_table", table_out[0], 0);
    check("abort_mcnt", mcnt[0], 0);
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done[0] || busy[0]) saw_done = 1;
    end
    check("abort_no_done", saw_done, 0);

    // reset and start together
    rst = 1'b1; start[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start[0] = 1'b0;
    check("rst_beats_start", busy[0], 0);

    sweep(0, 16'h6996, 16'h6996, 0, 0);
    sweep(0, 16'h6996, 16'h6997, 1, 1);
    sweep(1, 16'h6996, 16'h6996, 0, 0);
    sweep(1, 16'h6996, 16'h69D6, 1, 1);

    for (int r = 0; r < 8; r++) begin
      logic [15:0] fn, ex;
      fn = 16'($urandom);
      ex = (r % 3 == 0) ? fn : ((r % 3 == 1) ? (fn ^ (16'd1 << $urandom_range(15, 0))) : 16'($urandom));
      sweep(r % 2, fn, ex, r[0], r[1]);
    end
    sweep(0, 16'h0000, 16'hFFFF, 0, 0);
    sweep(1, 16'h8000, 16'h0000, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
